// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for small sequential controllers:
// the two-state ownership FSM encoding and a clog2 helper.
package shared_reg_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   // Ceiling log2, floored at 1 so index vectors never collapse to zero width.
   function automatic int clog2_f(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_en_reg.sv
// Enable register: loads d when en is high, otherwise holds; clears on reset.
module en_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         r_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Storage flop with load enable and asynchronous clear.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n)    q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   winner,
   output logic            any
);

   // Scan from farthest to nearest so the bit closest to ptr is assigned last.
   always_comb begin
      int idx;
      winner = '0;
      any    = |req;
      idx    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) winner = PW'(idx);
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared register with round-robin write arbitration and optional lock
// ownership: a locking winner keeps exclusive write access until it drops lock.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   localparam int PW   = clog2_f(NREQ)
) (
   input  logic                  clk,
   input  logic                  r_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       lock,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  q_valid,
   output logic [PW-1:0]         owner,
   output logic                  locked
);

   arb_state_e      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            q_valid_q, q_valid_d;
   logic            wr_en;
   logic [PW-1:0]   wr_sel;
   logic [PW-1:0]   winner;
   logic            any;
   logic [WIDTH-1:0] wdata_arr [NREQ];

   // Successor of a requester index, wrapping NREQ-1 back to 0.
   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
      return (x == PW'(NREQ - 1)) ? '0 : x + PW'(1);
   endfunction

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_wdata
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
   end

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any)
   );

   en_reg #(.W(WIDTH)) u_q (
      .clk (clk),
      .r_n (r_n),
      .en  (wr_en),
      .d   (wdata_arr[wr_sel]),
      .q   (q)
   );

   // Next-state: arbitrate in IDLE, serve only the owner in OWN.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      q_valid_d = q_valid_q;
      gnt_d     = '0;
      wr_en     = 1'b0;
      wr_sel    = owner_q;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               wr_en         = 1'b1;
               wr_sel        = winner;
               gnt_d[winner] = 1'b1;
               owner_d       = winner;
               q_valid_d     = 1'b1;
               if (lock[winner]) state_d = ST_OWN;
               else              ptr_d   = next_idx(winner);
            end
         end
         ST_OWN: begin
            if (req[owner_q]) begin
               wr_en          = 1'b1;
               gnt_d[owner_q] = 1'b1;
               q_valid_d      = 1'b1;
            end
            if (!lock[owner_q]) begin
               state_d = ST_IDLE;
               ptr_d   = next_idx(owner_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers, cleared asynchronously so ownership is abandoned on reset.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign gnt     = gnt_q;
   assign q_valid = q_valid_q;
   assign owner   = owner_q;
   assign locked  = (state_q == ST_OWN);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (WIDTH=8, NREQ=4) with a scoreboard
// of per-cycle expected outputs.
module tb_shared_reg_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] q;
      logic [1:0] owner;
      logic       qv;
      logic       lk;
   } exp_t;

   logic        clk = 1'b0;
   logic        r_n;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic        q_valid;
   logic [1:0]  owner;
   logic        locked;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   shared_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk     (clk),
      .r_n     (r_n),
      .req     (req),
      .lock    (lock),
      .wdata   (wdata),
      .gnt     (gnt),
      .q       (q),
      .q_valid (q_valid),
      .owner   (owner),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] qd, input logic [1:0] own,
                       input logic qv, input logic lk);
      exp_t e;
      e.gnt = g; e.q = qd; e.owner = own; e.qv = qv; e.lk = lk;
      sb.push_back(e);
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      wdata = {d3, d2, d1, d0};
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".gnt"},    32'(gnt),     32'h0);
      chk({tag, ".q"},      32'(q),       32'h0);
      chk({tag, ".q_valid"},32'(q_valid), 32'h0);
      chk({tag, ".owner"},  32'(owner),   32'h0);
      chk({tag, ".locked"}, 32'(locked),  32'h0);
   endtask

   // One clock: let the edge happen, then compare against the oldest expectation.
   task automatic cycle(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'h1);
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
         chk({tag, ".q"},       32'(q),       32'(e.q));
         chk({tag, ".owner"},   32'(owner),   32'(e.owner));
         chk({tag, ".q_valid"}, 32'(q_valid), 32'(e.qv));
         chk({tag, ".locked"},  32'(locked),  32'(e.lk));
      end
   endtask

   initial begin
      r_n = 1'b0; req = '0; lock = '0; wdata = '0;
      @(posedge clk); #1;
      check_zero("reset");
      #2 r_n = 1'b1;

      // Single write from requester 2; pointer moves to 3.
      req = 4'b0100; set_data(8'h00, 8'h00, 8'hA5, 8'h00);
      push(4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0); cycle("w2");
      req = 4'b0000;
      push(4'b0000, 8'hA5, 2'd2, 1'b1, 1'b0); cycle("w2_hold");

      // Wrap-around from ptr=3: grant 3 then 0.
      req = 4'b1001; set_data(8'hC0, 8'h00, 8'h00, 8'hC3);
      push(4'b1000, 8'hC3, 2'd3, 1'b1, 1'b0); cycle("wrap3");
      req = 4'b0001;
      push(4'b0001, 8'hC0, 2'd0, 1'b1, 1'b0); cycle("wrap0");
      req = 4'b0000;
      push(4'b0000, 8'hC0, 2'd0, 1'b1, 1'b0); cycle("wrap_idle");

      // Reset to restart the pointer at 0.
      #2 r_n = 1'b0;
      #1 check_zero("rst2");
      #1 r_n = 1'b1;

      // All four request, each drops after its grant.
      req = 4'b1111; lock = '0; set_data(8'h10, 8'h11, 8'h12, 8'h13);
      push(4'b0001, 8'h10, 2'd0, 1'b1, 1'b0); cycle("rr0");
      req = 4'b1110;
      push(4'b0010, 8'h11, 2'd1, 1'b1, 1'b0); cycle("rr1");
      req = 4'b1100;
      push(4'b0100, 8'h12, 2'd2, 1'b1, 1'b0); cycle("rr2");
      req = 4'b1000;
      push(4'b1000, 8'h13, 2'd3, 1'b1, 1'b0); cycle("rr3");
      req = 4'b0000;
      push(4'b0000, 8'h13, 2'd3, 1'b1, 1'b0); cycle("rr_idle");

      // Sustained all-request: fair rotation over two rounds.
      req = 4'b1111;
      for (int i = 0; i < 8; i++)
         push(4'(1 << (i % 4)), 8'(8'h10 + i % 4), 2'(i % 4), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle("fair");
      req = 4'b0000;
      push(4'b0000, 8'h13, 2'd3, 1'b1, 1'b0); cycle("fair_idle");

      // Lock without req is ignored in IDLE.
      lock = 4'b1111;
      push(4'b0000, 8'h13, 2'd3, 1'b1, 1'b0); cycle("lock_noreq");
      lock = 4'b0000;

      // Move ptr to 1, then requester 1 locks while 0 and 2 wait.
      req = 4'b0001; set_data(8'hE0, 8'h33, 8'hE2, 8'h00);
      push(4'b0001, 8'hE0, 2'd0, 1'b1, 1'b0); cycle("pre_lock");
      req = 4'b0111; lock = 4'b0010;
      push(4'b0010, 8'h33, 2'd1, 1'b1, 1'b1); cycle("lock33");
      set_data(8'hE0, 8'h34, 8'hE2, 8'h00);
      push(4'b0010, 8'h34, 2'd1, 1'b1, 1'b1); cycle("own34");
      set_data(8'hE0, 8'h35, 8'hE2, 8'h00);
      push(4'b0010, 8'h35, 2'd1, 1'b1, 1'b1); cycle("own35");
      set_data(8'hE0, 8'h36, 8'hE2, 8'h00);
      push(4'b0010, 8'h36, 2'd1, 1'b1, 1'b1); cycle("own36");
      req = 4'b0101; lock = 4'b0000;
      push(4'b0000, 8'h36, 2'd1, 1'b1, 1'b0); cycle("unlock");
      push(4'b0100, 8'hE2, 2'd2, 1'b1, 1'b0); cycle("after2");
      req = 4'b0001;
      push(4'b0001, 8'hE0, 2'd0, 1'b1, 1'b0); cycle("after0");
      req = 4'b0000;

      // Owner 3 writes 0x77 on the same edge it drops lock; ptr becomes 0.
      req = 4'b1000; lock = 4'b1000; set_data(8'h00, 8'h00, 8'h00, 8'h70);
      push(4'b1000, 8'h70, 2'd3, 1'b1, 1'b1); cycle("lock3");
      lock = 4'b0000; set_data(8'h00, 8'h00, 8'h00, 8'h77);
      push(4'b1000, 8'h77, 2'd3, 1'b1, 1'b0); cycle("drop77");
      req = 4'b1111; set_data(8'h10, 8'h11, 8'h12, 8'h13);
      push(4'b0001, 8'h10, 2'd0, 1'b1, 1'b0); cycle("ptr0");
      req = 4'b0000;

      // Lock with 0x5A, then asynchronous reset while owned.
      req = 4'b0100; lock = 4'b0100; set_data(8'h00, 8'h00, 8'h5A, 8'h00);
      push(4'b0100, 8'h5A, 2'd2, 1'b1, 1'b1); cycle("lock5a");
      req = 4'b0000;
      push(4'b0000, 8'h5A, 2'd2, 1'b1, 1'b1); cycle("held5a");
      #2 r_n = 1'b0;
      #1 check_zero("async_rst");
      #1 r_n = 1'b1;
      req = 4'b1111; lock = 4'b0000; set_data(8'h10, 8'h11, 8'h12, 8'h13);
      push(4'b0001, 8'h10, 2'd0, 1'b1, 1'b0); cycle("post_rst");
      req = 4'b0000;
      push(4'b0000, 8'h10, 2'd0, 1'b1, 1'b0); cycle("final_idle");

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
